scale_measure_controller: RTL and testbench
===========================================

Name: scale_measure_controller

Overview:
Sequences one smart-scale measurement for the BMI datapath. On start it latches height and collects NSAMP weight samples from the load-cell interface. It checks that the samples are stable and averages them. It then drives the averaged weight and latched height into the BMI classifier, waits its latency, and latches a one-hot BMI class. The result is held until the host acknowledges it.

Parameters:
NSAMP, 4, weight samples per attempt; power of 2, 2..16
TOL, 3, max allowed (max - min) spread across one attempt's samples, in weight LSBs
CALC_LAT, 2, cycles from dp_en rise to valid classifier flags
MAX_RETRY, 3, unstable attempts allowed before err_unstable
TIMEOUT, 255, idle cycles without w_valid in SAMPLE before err_timeout

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
start  in  1  pulse; begins a measurement; ignored unless in IDLE
h_in  in  8  height; latched on accepted start
w_valid  in  1  weight sample strobe; one sample per high cycle
w_in  in  9  weight sample
dp_weight  out  9  averaged weight to classifier
dp_height  out  8  latched height to classifier
dp_en  out  1  high during COMPUTE
dp_over  in  1  classifier overweight flag
dp_norm  in  1  classifier normal_bmi flag
dp_under  in  1  classifier underweight flag
busy  out  1  high in every state except IDLE
res_valid  out  1  result/error present (DONE)
res_class  out  2  00 none, 01 under, 10 normal, 11 over
res_weight  out  9  averaged weight of the result
err_unstable  out  1  retries exhausted
err_timeout  out  1  sample timeout
err_class  out  1  classifier flags not one-hot
ack  in  1  host consumes the result; effective only in DONE

Behaviour:
- Reset: synchronous, active-high. Every output is 0. State goes to IDLE; counters, sum, min/max and retry count clear. rst overrides all other inputs in any state.
- States: IDLE, SAMPLE, COMPUTE, DONE. All outputs are registered.
- IDLE -> SAMPLE on start: latch h_in into dp_height; clear sum, count and retry count; min=511, max=0; clear the timeout counter.
- SAMPLE:
  - Each w_valid cycle: sum += w_in; count++; update min/max; timeout counter clears.
  - Sum width = 9 + log2(NSAMP); no overflow is possible.
  - A sample arriving with w_valid on the entry cycle is not accepted. Sampling starts the cycle after entry.
  - When count reaches NSAMP, the next cycle evaluates the attempt:
    - If max - min <= TOL: dp_weight = sum >> log2(NSAMP) (truncate); go to COMPUTE.
    - Else if retry < MAX_RETRY: retry++; clear sum/count/min/max; stay in SAMPLE.
    - Else: set err_unstable; go to DONE with res_class=00.
  - w_valid during the evaluate cycle is dropped.
  - Timeout counter increments on cycles without w_valid. When it reaches TIMEOUT: set err_timeout; go to DONE with res_class=00. A sample arriving on that same cycle is dropped.
- COMPUTE:
  - dp_en=1 for exactly CALC_LAT cycles; dp_weight and dp_height held stable.
  - On the last cycle, sample the flags:
    - 100 -> 11, 010 -> 10, 001 -> 01.
    - Any other pattern -> 00 with err_class=1.
  - Next state is DONE; dp_en drops on entry to DONE.
- DONE:
  - res_valid=1; res_class, res_weight and error bits held.
  - res_weight = dp_weight, or 0 on an error path.
  - ack -> IDLE the next cycle; res_valid and error bits clear on that edge.
  - start is ignored while in DONE.
- start and ack are ignored outside IDLE and DONE respectively. Simultaneous start+ack in DONE: ack is taken and start is dropped.

Test Plan:
- Nominal: h_in=170, samples 330,331,332,331, dp flags 100 -> dp_weight=331, dp_en high 2 cycles, res_class=11, res_weight=331, res_valid held until ack, then busy=0 the next cycle.
- Unstable retry: first attempt 300,310,300,300 (spread 10) -> retry, no dp_en. Second attempt 80,80,81,81 with flags 010 -> dp_weight=80, res_class=10.
- Exhausted retries: 4 attempts each with spread 20 -> err_unstable=1, res_class=00, res_weight=0, dp_en never asserted.
- Timeout: start, 2 samples, then w_valid low 255 cycles -> err_timeout=1 exactly at the 255th idle cycle; a sample on that cycle is not counted.
- Bad classifier: flags 110 during COMPUTE -> err_class=1, res_class=00. Also flags 000 -> same response.
- Reset mid-operation: rst asserted in SAMPLE after 2 samples and again in COMPUTE -> all outputs 0 the next cycle, state IDLE. A following start runs a clean measurement with sum starting from 0.

Source files
------------

// File: rtl/scale_measure_controller.sv
// rtl/scale_measure_controller.sv - smart-scale measurement sequencer for the BMI datapath
//
// Purpose:
//   Runs one measurement. It latches the height, then collects NSAMP weight
//   samples, and checks that their spread is within TOL. When the samples are
//   stable it averages them and drives the average into the BMI classifier
//   for CALC_LAT cycles. It then latches a 2-bit class and holds the result
//   until the host sends ack. Unstable attempts are retried up to MAX_RETRY
//   times. A stalled load cell ends the run with err_timeout.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   start, h_in                   begin a measurement (IDLE only), height to latch
//   w_valid, w_in                 weight sample strobe and value
//   dp_weight, dp_height, dp_en   classifier operands and enable (COMPUTE)
//   dp_over, dp_norm, dp_under    classifier flags
//   busy                          high outside IDLE
//   res_valid, res_class,
//   res_weight                    result held in DONE
//   err_unstable, err_timeout,
//   err_class                     error indications held in DONE
//   ack                           host consumes the result (DONE only)

module scale_measure_controller #(
  parameter int NSAMP     = 4,
  parameter int TOL       = 3,
  parameter int CALC_LAT  = 2,
  parameter int MAX_RETRY = 3,
  parameter int TIMEOUT   = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] h_in,
  input  logic       w_valid,
  input  logic [8:0] w_in,
  output logic [8:0] dp_weight,
  output logic [7:0] dp_height,
  output logic       dp_en,
  input  logic       dp_over,
  input  logic       dp_norm,
  input  logic       dp_under,
  output logic       busy,
  output logic       res_valid,
  output logic [1:0] res_class,
  output logic [8:0] res_weight,
  output logic       err_unstable,
  output logic       err_timeout,
  output logic       err_class,
  input  logic       ack
);

  localparam int LOG2N = $clog2(NSAMP);
  localparam int SW    = 9 + LOG2N;
  localparam int CW    = LOG2N + 1;
  localparam int TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int RW    = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int LW    = (CALC_LAT > 1) ? $clog2(CALC_LAT) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SAMPLE  = 2'd1,
    S_COMPUTE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] sum_q, sum_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [8:0]    min_q, min_d;
  logic [8:0]    max_q, max_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [LW-1:0] lat_q, lat_d;

  logic [8:0]    dp_weight_q, dp_weight_d;
  logic [7:0]    dp_height_q, dp_height_d;
  logic          dp_en_q, dp_en_d;
  logic          busy_q, busy_d;
  logic          res_valid_q, res_valid_d;
  logic [1:0]    res_class_q, res_class_d;
  logic [8:0]    res_weight_q, res_weight_d;
  logic          err_unstable_q, err_unstable_d;
  logic          err_timeout_q, err_timeout_d;
  logic          err_class_q, err_class_d;

  // max_q >= min_q whenever this is consulted (at least one sample taken).
  logic [8:0] spread;
  assign spread = max_q - min_q;

  always_comb begin
    state_d        = state_q;
    sum_d          = sum_q;
    cnt_d          = cnt_q;
    min_d          = min_q;
    max_d          = max_q;
    retry_d        = retry_q;
    tmo_d          = tmo_q;
    lat_d          = lat_q;
    dp_weight_d    = dp_weight_q;
    dp_height_d    = dp_height_q;
    res_class_d    = res_class_q;
    res_weight_d   = res_weight_q;
    err_unstable_d = err_unstable_q;
    err_timeout_d  = err_timeout_q;
    err_class_d    = err_class_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_SAMPLE;
          dp_height_d = h_in;
          sum_d       = '0;
          cnt_d       = '0;
          retry_d     = '0;
          min_d       = 9'd511;
          max_d       = 9'd0;
          tmo_d       = '0;
        end
      end

      S_SAMPLE: begin
        if (cnt_q == CW'(NSAMP)) begin
          // Evaluate cycle: any sample offered now is dropped.
          if (spread <= 9'(TOL)) begin
            dp_weight_d = sum_q[SW-1:LOG2N];
            lat_d       = '0;
            state_d     = S_COMPUTE;
          end else if (retry_q < RW'(MAX_RETRY)) begin
            retry_d = retry_q + RW'(1);
            sum_d   = '0;
            cnt_d   = '0;
            min_d   = 9'd511;
            max_d   = 9'd0;
            tmo_d   = '0;
          end else begin
            err_unstable_d = 1'b1;
            res_class_d    = 2'b00;
            res_weight_d   = 9'd0;
            state_d        = S_DONE;
          end
        end else if (w_valid) begin
          sum_d = sum_q + SW'(w_in);
          cnt_d = cnt_q + CW'(1);
          if (w_in < min_q) min_d = w_in;
          if (w_in > max_q) max_d = w_in;
          tmo_d = '0;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          // This idle cycle is the TIMEOUT-th in a row.
          err_timeout_d = 1'b1;
          res_class_d   = 2'b00;
          res_weight_d  = 9'd0;
          state_d       = S_DONE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      S_COMPUTE: begin
        if (lat_q == LW'(CALC_LAT - 1)) begin
          state_d      = S_DONE;
          res_weight_d = dp_weight_q;
          case ({dp_over, dp_norm, dp_under})
            3'b100:  res_class_d = 2'b11;
            3'b010:  res_class_d = 2'b10;
            3'b001:  res_class_d = 2'b01;
            default: begin
              res_class_d  = 2'b00;
              res_weight_d = 9'd0;
              err_class_d  = 1'b1;
            end
          endcase
        end else begin
          lat_d = lat_q + LW'(1);
        end
      end

      S_DONE: begin
        if (ack) begin
          state_d        = S_IDLE;
          res_class_d    = 2'b00;
          res_weight_d   = 9'd0;
          err_unstable_d = 1'b0;
          err_timeout_d  = 1'b0;
          err_class_d    = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Status outputs are registered copies of the upcoming state.
    dp_en_d     = (state_d == S_COMPUTE);
    busy_d      = (state_d != S_IDLE);
    res_valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      sum_q          <= '0;
      cnt_q          <= '0;
      min_q          <= '0;
      max_q          <= '0;
      retry_q        <= '0;
      tmo_q          <= '0;
      lat_q          <= '0;
      dp_weight_q    <= '0;
      dp_height_q    <= '0;
      dp_en_q        <= 1'b0;
      busy_q         <= 1'b0;
      res_valid_q    <= 1'b0;
      res_class_q    <= '0;
      res_weight_q   <= '0;
      err_unstable_q <= 1'b0;
      err_timeout_q  <= 1'b0;
      err_class_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      sum_q          <= sum_d;
      cnt_q          <= cnt_d;
      min_q          <= min_d;
      max_q          <= max_d;
      retry_q        <= retry_d;
      tmo_q          <= tmo_d;
      lat_q          <= lat_d;
      dp_weight_q    <= dp_weight_d;
      dp_height_q    <= dp_height_d;
      dp_en_q        <= dp_en_d;
      busy_q         <= busy_d;
      res_valid_q    <= res_valid_d;
      res_class_q    <= res_class_d;
      res_weight_q   <= res_weight_d;
      err_unstable_q <= err_unstable_d;
      err_timeout_q  <= err_timeout_d;
      err_class_q    <= err_class_d;
    end
  end

  assign dp_weight    = dp_weight_q;
  assign dp_height    = dp_height_q;
  assign dp_en        = dp_en_q;
  assign busy         = busy_q;
  assign res_valid    = res_valid_q;
  assign res_class    = res_class_q;
  assign res_weight   = res_weight_q;
  assign err_unstable = err_unstable_q;
  assign err_timeout  = err_timeout_q;
  assign err_class    = err_class_q;

endmodule

// File: tb/tb_scale_measure_controller.sv
// tb/tb_scale_measure_controller.sv - self-checking bench for scale_measure_controller

module tb_scale_measure_controller;

  localparam int NSAMP     = 4;
  localparam int TOL       = 3;
  localparam int CALC_LAT  = 2;
  localparam int MAX_RETRY = 3;
  localparam int TIMEOUT   = 255;

  logic       clk = 1'b0;
  logic       rst, start, w_valid, dp_over, dp_norm, dp_under, ack;
  logic [7:0] h_in;
  logic [8:0] w_in;
  logic [8:0] dp_weight, res_weight;
  logic [7:0] dp_height;
  logic       dp_en, busy, res_valid, err_unstable, err_timeout, err_class;
  logic [1:0] res_class;

  always #5 clk = ~clk;

  scale_measure_controller #(
    .NSAMP(NSAMP), .TOL(TOL), .CALC_LAT(CALC_LAT),
    .MAX_RETRY(MAX_RETRY), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .h_in(h_in),
    .w_valid(w_valid), .w_in(w_in),
    .dp_weight(dp_weight), .dp_height(dp_height), .dp_en(dp_en),
    .dp_over(dp_over), .dp_norm(dp_norm), .dp_under(dp_under),
    .busy(busy), .res_valid(res_valid), .res_class(res_class),
    .res_weight(res_weight), .err_unstable(err_unstable),
    .err_timeout(err_timeout), .err_class(err_class), .ack(ack)
  );

  // Behavioural model: a phase, the list of samples accepted in the current
  // attempt, and the expected value of every output.
  int ph;
  int q[$];
  int retries, idle_run, lat;
  int lo, hi, tot;
  logic [2:0] fl;
  int e_weight, e_height, e_en, e_busy, e_valid, e_class, e_rweight;
  int e_eu, e_et, e_ec;

  always @(posedge clk) begin
    if (rst) begin
      ph = 0; q.delete(); retries = 0; idle_run = 0; lat = 0;
      e_weight = 0; e_height = 0; e_en = 0; e_busy = 0; e_valid = 0;
      e_class = 0; e_rweight = 0; e_eu = 0; e_et = 0; e_ec = 0;
    end else begin
      case (ph)
        0: if (start) begin
          ph = 1; e_height = int'(h_in); q.delete();
          retries = 0; idle_run = 0; e_busy = 1;
        end
        1: begin
          if (q.size() == NSAMP) begin
            lo = q[0]; hi = q[0]; tot = 0;
            foreach (q[i]) begin
              tot += q[i];
              if (q[i] < lo) lo = q[i];
              if (q[i] > hi) hi = q[i];
            end
            if (hi - lo <= TOL) begin
              e_weight = tot / NSAMP; ph = 2; lat = 0; e_en = 1;
            end else if (retries < MAX_RETRY) begin
              retries++; q.delete(); idle_run = 0;
            end else begin
              ph = 3; e_valid = 1; e_class = 0; e_rweight = 0; e_eu = 1;
            end
          end else if (w_valid) begin
            q.push_back(int'(w_in)); idle_run = 0;
          end else begin
            idle_run++;
            if (idle_run == TIMEOUT) begin
              ph = 3; e_valid = 1; e_class = 0; e_rweight = 0; e_et = 1;
            end
          end
        end
        2: begin
          lat++;
          if (lat == CALC_LAT) begin
            ph = 3; e_en = 0; e_valid = 1;
            fl = {dp_over, dp_norm, dp_under};
            if (fl == 3'b100)      begin e_class = 3; e_rweight = e_weight; end
            else if (fl == 3'b010) begin e_class = 2; e_rweight = e_weight; end
            else if (fl == 3'b001) begin e_class = 1; e_rweight = e_weight; end
            else begin e_class = 0; e_rweight = 0; e_ec = 1; end
          end
        end
        default: if (ack) begin
          ph = 0; e_valid = 0; e_class = 0; e_rweight = 0;
          e_eu = 0; e_et = 0; e_ec = 0; e_busy = 0;
        end
      endcase
    end
  end

  int n_pass = 0;
  int n_total = 0;
  int en_total = 0;
  bit chk_en = 0;

  task automatic cmp(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Advance one cycle; at the falling edge compare every output with the model.
  task automatic cyc();
    @(negedge clk);
    if (dp_en) en_total++;
    if (chk_en) begin
      cmp("dp_weight",    int'(dp_weight),    e_weight);
      cmp("dp_height",    int'(dp_height),    e_height);
      cmp("dp_en",        int'(dp_en),        e_en);
      cmp("busy",         int'(busy),         e_busy);
      cmp("res_valid",    int'(res_valid),    e_valid);
      cmp("res_class",    int'(res_class),    e_class);
      cmp("res_weight",   int'(res_weight),   e_rweight);
      cmp("err_unstable", int'(err_unstable), e_eu);
      cmp("err_timeout",  int'(err_timeout),  e_et);
      cmp("err_class",    int'(err_class),    e_ec);
    end
  endtask

  task automatic do_start(input int h);
    h_in = 8'(h); start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic send(input int w);
    w_valid = 1'b1; w_in = 9'(w);
    cyc();
    w_valid = 1'b0;
  endtask

  task automatic set_flags(input logic [2:0] f);
    {dp_over, dp_norm, dp_under} = f;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (!res_valid && k < 50) begin cyc(); k++; end
    cmp("done_reached", int'(res_valid), 1);
  endtask

  task automatic do_ack();
    ack = 1'b1;
    cyc();
    ack = 1'b0;
  endtask

  int base;
  int k;
  int att[4] = '{100, 120, 100, 100};
  int rtr[9] = '{300, 310, 300, 300, 999, 80, 80, 81, 81};

  initial begin
    rst = 1'b1; start = 1'b0; h_in = '0; w_valid = 1'b0; w_in = '0;
    dp_over = 1'b0; dp_norm = 1'b0; dp_under = 1'b0; ack = 1'b0;
    cyc(); cyc();
    chk_en = 1;
    cyc();
    cmp("reset_busy", int'(busy), 0);
    cmp("reset_res_valid", int'(res_valid), 0);
    cmp("reset_dp_height", int'(dp_height), 0);
    rst = 1'b0;
    cyc();

    // Nominal; a sample offered together with start is ignored.
    set_flags(3'b100);
    base = en_total;
    w_valid = 1'b1; w_in = 9'd500;
    do_start(170);
    send(330); send(331); send(332); send(331);
    wait_done();
    cmp("nom_dp_weight", int'(dp_weight), 331);
    cmp("nom_dp_height", int'(dp_height), 170);
    cmp("nom_class", int'(res_class), 3);
    cmp("nom_res_weight", int'(res_weight), 331);
    cmp("nom_en_cycles", en_total - base, 2);
    start = 1'b1; cyc(); start = 1'b0; cyc(); cyc();
    cmp("nom_hold_valid", int'(res_valid), 1);
    do_ack();
    cmp("nom_ack_valid", int'(res_valid), 0);
    cmp("nom_ack_busy", int'(busy), 0);
    cyc();

    // Unstable first attempt, sample during evaluate dropped, second attempt stable.
    set_flags(3'b010);
    base = en_total;
    do_start(160);
    foreach (rtr[i]) send(rtr[i]);
    wait_done();
    cmp("rtr_dp_weight", int'(dp_weight), 80);
    cmp("rtr_class", int'(res_class), 2);
    cmp("rtr_res_weight", int'(res_weight), 80);
    cmp("rtr_en_cycles", en_total - base, 2);
    start = 1'b1; ack = 1'b1; cyc(); start = 1'b0; ack = 1'b0;
    cyc();
    cmp("start_ack_busy", int'(busy), 0);

    // Retries exhausted.
    set_flags(3'b100);
    base = en_total;
    do_start(150);
    for (int a = 0; a < 4; a++) begin
      foreach (att[i]) send(att[i]);
      cyc();
    end
    wait_done();
    cmp("uns_err", int'(err_unstable), 1);
    cmp("uns_class", int'(res_class), 0);
    cmp("uns_res_weight", int'(res_weight), 0);
    cmp("uns_en_cycles", en_total - base, 0);
    do_ack(); cyc();

    // Timeout after two samples.
    do_start(140);
    send(210); send(211);
    k = 0;
    while (!err_timeout && k < 400) begin cyc(); k++; end
    cmp("tmo_idle_cycles", k, 255);
    cmp("tmo_err", int'(err_timeout), 1);
    send(50);
    cmp("tmo_res_weight", int'(res_weight), 0);
    cmp("tmo_still_valid", int'(res_valid), 1);
    do_ack(); cyc();

    // Classifier flags not one-hot.
    set_flags(3'b110);
    do_start(175);
    send(50); send(51); send(50); send(51);
    wait_done();
    cmp("cls110_err", int'(err_class), 1);
    cmp("cls110_class", int'(res_class), 0);
    cmp("cls110_dp_weight", int'(dp_weight), 50);
    do_ack(); cyc();
    set_flags(3'b000);
    do_start(175);
    send(60); send(61); send(62); send(63);
    wait_done();
    cmp("cls000_err", int'(err_class), 1);
    cmp("cls000_res_weight", int'(res_weight), 0);
    do_ack(); cyc();

    // Reset in SAMPLE, then in COMPUTE, then a clean run.
    do_start(190);
    send(500); send(500);
    rst = 1'b1; cyc(); rst = 1'b0;
    cmp("rst_s_busy", int'(busy), 0);
    cmp("rst_s_dp_height", int'(dp_height), 0);
    set_flags(3'b100);
    do_start(150);
    send(400); send(400); send(401); send(401);
    cyc();
    cmp("pre_rst_dp_en", int'(dp_en), 1);
    rst = 1'b1; cyc(); rst = 1'b0;
    cmp("rst_c_dp_en", int'(dp_en), 0);
    cmp("rst_c_dp_weight", int'(dp_weight), 0);
    set_flags(3'b001);
    do_start(180);
    send(200); send(201); send(202); send(203);
    wait_done();
    cmp("clean_dp_weight", int'(dp_weight), 201);
    cmp("clean_dp_height", int'(dp_height), 180);
    cmp("clean_class", int'(res_class), 1);
    do_ack(); cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
